// File: rtl/barrel_unrotator_pipe.sv
// Pipelined rotate-right unit with valid/ready handshakes; recovers words rotated left by N.
// Optional parity carry/check is built when BARREL_UNROT_PARITY_EN is defined.
module barrel_unrotator_pipe #(
  parameter int SHAMT_W = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_zero,
  output logic [CNT_W-1:0]   op_count
`ifdef BARREL_UNROT_PARITY_EN
  ,
  input  logic               par_inject,
  output logic               par_err,
  output logic               par_sticky
`endif
);

  localparam int LAST = SHAMT_W - 1;

  generate
    if (DATA_W != (1 << SHAMT_W)) begin : g_bad_width
      $error("barrel_unrotator_pipe: DATA_W must equal 2**SHAMT_W");
    end
  endgenerate

  logic               valid_q [SHAMT_W];
  logic               valid_d [SHAMT_W];
  logic [DATA_W-1:0]  data_q  [SHAMT_W];
  logic [DATA_W-1:0]  data_d  [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_q [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_d [SHAMT_W];
  logic               zero_q  [SHAMT_W];
  logic               zero_d  [SHAMT_W];
`ifdef BARREL_UNROT_PARITY_EN
  logic               par_q   [SHAMT_W];
  logic               par_d   [SHAMT_W];
  logic               par_sticky_q;
`endif
  logic [CNT_W-1:0]   count_q;
  logic               advance;

  function automatic logic [DATA_W-1:0] ror_pow2(input logic [DATA_W-1:0] d, input int k);
    int sh;
    sh = 1 << k;
    return (d >> sh) | (d << (DATA_W - sh));
  endfunction

  // The whole pipe moves as one; a stalled output freezes every stage, bubbles included.
  assign advance  = !valid_q[LAST] || out_ready;
  assign in_ready = advance;

  always_comb begin
    for (int k = 0; k < SHAMT_W; k++) begin
      valid_d[k] = 1'b0;
      data_d[k]  = '0;
      shamt_d[k] = '0;
      zero_d[k]  = 1'b0;
`ifdef BARREL_UNROT_PARITY_EN
      par_d[k]   = 1'b0;
`endif
    end
    valid_d[0] = in_valid;
    shamt_d[0] = in_shamt;
    data_d[0]  = in_shamt[0] ? ror_pow2(in_data, 0) : in_data;
    zero_d[0]  = in_valid && (data_d[0] == '0);
`ifdef BARREL_UNROT_PARITY_EN
    par_d[0]   = (^in_data) ^ par_inject;
`endif
    for (int k = 1; k < SHAMT_W; k++) begin
      valid_d[k] = valid_q[k-1];
      shamt_d[k] = shamt_q[k-1];
      data_d[k]  = shamt_q[k-1][k] ? ror_pow2(data_q[k-1], k) : data_q[k-1];
      zero_d[k]  = valid_q[k-1] && (data_d[k] == '0);
`ifdef BARREL_UNROT_PARITY_EN
      par_d[k]   = par_q[k-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        zero_q[k]  <= 1'b0;
`ifdef BARREL_UNROT_PARITY_EN
        par_q[k]   <= 1'b0;
`endif
      end
    end else if (advance) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
        zero_q[k]  <= zero_d[k];
`ifdef BARREL_UNROT_PARITY_EN
        par_q[k]   <= par_d[k];
`endif
      end
    end
  end

  // Completed-transfer counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (valid_q[LAST] && out_ready && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_data  = data_q[LAST];
  assign out_zero  = zero_q[LAST];
  assign op_count  = count_q;

`ifdef BARREL_UNROT_PARITY_EN
  assign par_err = valid_q[LAST] && ((^data_q[LAST]) != par_q[LAST]);

  always_ff @(posedge clk) begin
    if (reset) begin
      par_sticky_q <= 1'b0;
    end else if (valid_q[LAST] && out_ready && par_err) begin
      par_sticky_q <= 1'b1;
    end
  end

  assign par_sticky = par_sticky_q;
`endif

endmodule

// File: tb/tb_barrel_unrotator_pipe.sv
// Directed self-checking bench for barrel_unrotator_pipe; parity checks only when BARREL_UNROT_PARITY_EN is defined.
module tb_barrel_unrotator_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero;
  logic [15:0] op_count;
`ifdef BARREL_UNROT_PARITY_EN
  logic        par_inject;
  logic        par_err;
  logic        par_sticky;
`endif

  int checks;
  int errors;

  barrel_unrotator_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .op_count  (op_count)
`ifdef BARREL_UNROT_PARITY_EN
    ,
    .par_inject(par_inject),
    .par_err   (par_err),
    .par_sticky(par_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rotate-left, the shifter whose effect the DUT undoes.
  function automatic logic [31:0] rol(input logic [31:0] d, input int n);
    logic [63:0] w;
    w = {d, d} << n;
    return w[63:32];
  endfunction

  task automatic test_reset;
    int early;
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hCAFEF00D; in_shamt = 5'd3; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 00000000", out_data); end
    checks++; if (op_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_op_count: got %0d expected 0", op_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_zero: got %b expected 0", out_zero); end
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("[TB] FAIL post_reset_idle: got %0d valid cycles expected 0", early); end
  endtask

  task automatic test_single;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'h12345678; in_shamt = 5'd4; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early: got %b expected 0", out_valid); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 32'h81234567) begin errors++; $display("[TB] FAIL single_data: got %h expected 81234567", out_data); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("[TB] FAIL single_zero: got %b expected 0", out_zero); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (op_count !== 16'd1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", op_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] din  [4];
    logic [4:0]  sh   [4];
    logic [31:0] dexp [4];
    logic        zexp [4];
    din[0] = 32'h80000001; sh[0] = 5'd1;  dexp[0] = 32'hC0000000; zexp[0] = 1'b0;
    din[1] = 32'hDEADBEEF; sh[1] = 5'd0;  dexp[1] = 32'hDEADBEEF; zexp[1] = 1'b0;
    din[2] = 32'h00000001; sh[2] = 5'd31; dexp[2] = 32'h00000002; zexp[2] = 1'b0;
    din[3] = 32'h00000000; sh[3] = 5'd17; dexp[3] = 32'h00000000; zexp[3] = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = din[i]; in_shamt = sh[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_data !== dexp[i]) begin errors++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, out_data, dexp[i]); end
      checks++; if (out_zero !== zexp[i]) begin errors++; $display("[TB] FAIL b2b_zero[%0d]: got %b expected %b", i, out_zero, zexp[i]); end
      @(posedge clk);
    end
    @(negedge clk);
    checks++; if (op_count !== 16'd5) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 5", op_count); end
  endtask

  task automatic test_backpressure;
    logic [31:0] din  [3];
    logic [4:0]  sh   [3];
    logic [31:0] dexp [3];
    int got;
    int bad_hold;
    din[0] = 32'h0000FFFF; sh[0] = 5'd8; dexp[0] = 32'hFF0000FF;
    din[1] = 32'hA5A5A5A5; sh[1] = 5'd1; dexp[1] = 32'hD2D2D2D2;
    din[2] = 32'h00000100; sh[2] = 5'd9; dexp[2] = 32'h80000000;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = din[i]; in_shamt = sh[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    bad_hold = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== dexp[0] || in_ready !== 1'b0 || out_zero !== 1'b0) bad_hold++;
      @(posedge clk);
    end
    checks++; if (bad_hold != 0) begin errors++; $display("[TB] FAIL stall_hold: got %0d unstable cycles expected 0", bad_hold); end
    #1;
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        checks++; if (out_data !== dexp[got]) begin errors++; $display("[TB] FAIL stall_order[%0d]: got %h expected %h", got, out_data, dexp[got]); end
        got++;
      end
      @(posedge clk);
    end
    checks++; if (got != 3) begin errors++; $display("[TB] FAIL stall_received: got %0d expected 3", got); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_dup: got %b expected 0", out_valid); end
    checks++; if (op_count !== 16'd8) begin errors++; $display("[TB] FAIL stall_count: got %0d expected 8", op_count); end
  endtask

  task automatic test_round_trip;
    logic [31:0] q [$];
    logic [31:0] exp_word;
    logic [31:0] orig;
    int n;
    int sent;
    int recv;
    sent = 0;
    recv = 0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 1100 && recv < 1000; cyc++) begin
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("[TB] FAIL rt_extra: got %h expected no output", out_data);
        end else begin
          exp_word = q.pop_front();
          checks++; if (out_data !== exp_word) begin errors++; $display("[TB] FAIL rt_data[%0d]: got %h expected %h", recv, out_data, exp_word); end
        end
        recv++;
      end
      if (sent < 1000) begin
        orig = $urandom;
        n = $urandom_range(0, 31);
        in_valid = 1'b1; in_data = rol(orig, n); in_shamt = n[4:0];
        q.push_back(orig);
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (recv != 1000) begin errors++; $display("[TB] FAIL rt_received: got %0d expected 1000", recv); end
    @(negedge clk);
    checks++; if (op_count !== 16'd1008) begin errors++; $display("[TB] FAIL rt_count: got %0d expected 1008", op_count); end
  endtask

  task automatic test_mid_reset;
    int leaked;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0F0F0F0F; in_shamt = 5'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    leaked = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) leaked++;
    end
    checks++; if (leaked != 0) begin errors++; $display("[TB] FAIL midreset_leak: got %0d valid cycles expected 0", leaked); end
    checks++; if (op_count !== 16'd0) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 0", op_count); end
  endtask

`ifdef BARREL_UNROT_PARITY_EN
  task automatic test_parity;
    logic perr_exp [3];
    logic stk_exp  [3];
    perr_exp[0] = 1'b0; perr_exp[1] = 1'b1; perr_exp[2] = 1'b0;
    stk_exp[0]  = 1'b0; stk_exp[1]  = 1'b0; stk_exp[2]  = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h13570000 + i; in_shamt = 5'(3 * i + 1);
      par_inject = (i == 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; par_inject = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (par_err !== perr_exp[i]) begin errors++; $display("[TB] FAIL par_err[%0d]: got %b expected %b", i, par_err, perr_exp[i]); end
      checks++; if (par_sticky !== stk_exp[i]) begin errors++; $display("[TB] FAIL par_sticky[%0d]: got %b expected %b", i, par_sticky, stk_exp[i]); end
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (par_sticky !== 1'b1) begin errors++; $display("[TB] FAIL par_sticky_hold: got %b expected 1", par_sticky); end
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (par_sticky !== 1'b0) begin errors++; $display("[TB] FAIL par_sticky_clear: got %b expected 0", par_sticky); end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_shamt = '0;
    out_ready = 1'b1;
`ifdef BARREL_UNROT_PARITY_EN
    par_inject = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_round_trip();
    test_mid_reset();
`ifdef BARREL_UNROT_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
